vc_fifo_buffer: RTL and testbench

Multi-virtual-channel input buffer for the router input channel. It replaces the single-queue FIFO with NUM_VC independent first-word-fall-through queues that share one write port and have one read port per VC. Each VC exposes occupancy, full, empty and almost-full status for credit-based flow control, plus sticky overflow/underflow error flags. It sits between the link receiver, which writes flits tagged with a VC, and the switch allocator, which reads VC heads.

---
 rtl/vc_fifo_buffer.sv | 97 +++++++++
 tb/tb_vc_fifo_buffer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_fifo_buffer.sv
// Multi-virtual-channel FWFT input buffer: one shared write port, one pop per VC,
// per-VC occupancy/credit status and sticky overflow/underflow error flags.
module vc_fifo_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADD_BIT      = 2,
  parameter int VC_BIT       = 1,
  parameter int AFULL_THRESH = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [DATA_WIDTH-1:0]                  Data_in,
  input  logic                                   write,
  input  logic [VC_BIT-1:0]                      wr_vc,
  input  logic [(2**VC_BIT)-1:0]                 read,
  input  logic                                   err_clr,
  output logic [(2**VC_BIT)*DATA_WIDTH-1:0]      Data_out,
  output logic [(2**VC_BIT)-1:0]                 empty,
  output logic [(2**VC_BIT)-1:0]                 full,
  output logic [(2**VC_BIT)-1:0]                 almost_full,
  output logic [(2**VC_BIT)*(ADD_BIT+1)-1:0]     count,
  output logic                                   err_ovf,
  output logic                                   err_udf
);

  localparam int DEPTH  = 2**ADD_BIT;
  localparam int NUM_VC = 2**VC_BIT;
  localparam int CW     = ADD_BIT + 1;

  logic [DATA_WIDTH-1:0] mem    [NUM_VC*DEPTH];
  logic [ADD_BIT-1:0]    wr_ptr [NUM_VC];
  logic [ADD_BIT-1:0]    rd_ptr [NUM_VC];
  logic [CW-1:0]         cnt    [NUM_VC];

  logic                  wacc;
  logic [NUM_VC-1:0]     racc;
  logic [NUM_VC-1:0]     wsel;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      empty[v]       = (cnt[v] == '0);
      full[v]        = (cnt[v] == CW'(DEPTH));
      almost_full[v] = (cnt[v] >= CW'(AFULL_THRESH));
    end
  end

  // A full VC can still take a write when it is popped in the same cycle.
  always_comb begin
    wacc = write & (~full[wr_vc] | read[wr_vc]);
    racc = read & ~empty;
    wsel = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wsel[v] = wacc && (wr_vc == VC_BIT'(v));
    end
  end

  // Storage is intentionally left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wacc) begin
      mem[{wr_vc, wr_ptr[wr_vc]}] <= Data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v]    <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (wsel[v]) wr_ptr[v] <= wr_ptr[v] + ADD_BIT'(1);
        if (racc[v]) rd_ptr[v] <= rd_ptr[v] + ADD_BIT'(1);
        cnt[v] <= cnt[v] + CW'(wsel[v]) - CW'(racc[v]);
      end
    end
  end

  // Sticky flags: a new error in the clearing cycle takes priority over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (write && !wacc) err_ovf <= 1'b1;
      else if (err_clr)   err_ovf <= 1'b0;
      if (|(read & empty)) err_udf <= 1'b1;
      else if (err_clr)    err_udf <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_out
    assign Data_out[g*DATA_WIDTH +: DATA_WIDTH] = mem[{VC_BIT'(g), rd_ptr[g]}];
    assign count[g*CW +: CW]                    = cnt[g];
  end

endmodule

// File: tb/tb_vc_fifo_buffer.sv
// Self-checking bench for vc_fifo_buffer: directed scenarios plus a randomized
// run, all checked against a queue-based reference model.
module tb_vc_fifo_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  Data_in;
  logic        write;
  logic        wr_vc;
  logic [1:0]  read;
  logic        err_clr;
  logic [15:0] Data_out;
  logic [1:0]  empty;
  logic [1:0]  full;
  logic [1:0]  almost_full;
  logic [5:0]  count;
  logic        err_ovf;
  logic        err_udf;

  int total = 0;
  int bad   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       ovf_m = 1'b0;
  logic       udf_m = 1'b0;

  vc_fifo_buffer #(
    .DATA_WIDTH(8), .ADD_BIT(2), .VC_BIT(1), .AFULL_THRESH(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Data_in(Data_in), .write(write), .wr_vc(wr_vc),
    .read(read), .err_clr(err_clr), .Data_out(Data_out), .empty(empty),
    .full(full), .almost_full(almost_full), .count(count),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] exp_count();
    return {3'(q1.size()), 3'(q0.size())};
  endfunction

  function automatic logic [1:0] exp_empty();
    return {q1.size() == 0, q0.size() == 0};
  endfunction

  function automatic logic [1:0] exp_full();
    return {q1.size() == 4, q0.size() == 4};
  endfunction

  function automatic logic [1:0] exp_af();
    return {q1.size() >= 3, q0.size() >= 3};
  endfunction

  // One clock of stimulus; the model is advanced from the queue contents seen before the edge.
  task automatic step(input logic w, input logic vc, input logic [7:0] d,
                      input logic [1:0] rd, input logic clr);
    int s0, s1, svc;
    logic [1:0] racc;
    logic wacc;
    s0 = q0.size();
    s1 = q1.size();
    svc = vc ? s1 : s0;
    racc[0] = rd[0] && (s0 > 0);
    racc[1] = rd[1] && (s1 > 0);
    wacc = w && ((svc < 4) || rd[vc]);
    write = w; wr_vc = vc; Data_in = d; read = rd; err_clr = clr;
    @(posedge clk);
    if (racc[0]) void'(q0.pop_front());
    if (racc[1]) void'(q1.pop_front());
    if (wacc) begin
      if (vc) q1.push_back(d);
      else    q0.push_back(d);
    end
    if (w && !wacc) ovf_m = 1'b1;
    else if (clr)   ovf_m = 1'b0;
    if ((rd[0] && s0 == 0) || (rd[1] && s1 == 0)) udf_m = 1'b1;
    else if (clr)                                  udf_m = 1'b0;
    #1;
    write = 1'b0; read = 2'b00; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    write = 1'b0; wr_vc = 1'b0; Data_in = 8'h00; read = 2'b00; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    total++;
    if (empty !== 2'b11 || full !== 2'b00 || almost_full !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_flags: got empty=%b full=%b af=%b expected 11 00 00",
               empty, full, almost_full);
    end
    total++;
    if (count !== 6'd0 || err_ovf !== 1'b0 || err_udf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_count_err: got count=%h ovf=%b udf=%b expected 0 0 0",
               count, err_ovf, err_udf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, vals[i], 2'b00, 1'b0);
      total++;
      if (almost_full[0] !== (i >= 2) || full[0] !== (i == 3)) begin
        bad++;
        $display("[TB] FAIL fill_status_%0d: got af=%b full=%b expected af=%b full=%b",
                 i, almost_full[0], full[0], (i >= 2), (i == 3));
      end
    end
    total++;
    if (Data_out[7:0] !== 8'h11) begin
      bad++;
      $display("[TB] FAIL fill_head: got %h expected 11", Data_out[7:0]);
    end
    step(1'b1, 1'b0, 8'h55, 2'b00, 1'b0);
    total++;
    if (err_ovf !== 1'b1 || count[2:0] !== 3'd4) begin
      bad++;
      $display("[TB] FAIL fill_overflow: got ovf=%b count0=%0d expected 1 4", err_ovf, count[2:0]);
    end
    step(1'b1, 1'b0, 8'h56, 2'b00, 1'b1);
    total++;
    if (err_ovf !== 1'b1) begin
      bad++;
      $display("[TB] FAIL set_beats_clear: got ovf=%b expected 1", err_ovf);
    end
    step(1'b0, 1'b0, 8'h00, 2'b00, 1'b1);
    total++;
    if (err_ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ovf_clear: got ovf=%b expected 0", err_ovf);
    end
  endtask

  task automatic test_drain();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (Data_out[7:0] !== vals[i]) begin
        bad++;
        $display("[TB] FAIL drain_data_%0d: got %h expected %h", i, Data_out[7:0], vals[i]);
      end
      step(1'b0, 1'b0, 8'h00, 2'b01, 1'b0);
    end
    total++;
    if (empty[0] !== 1'b1 || count[2:0] !== 3'd0) begin
      bad++;
      $display("[TB] FAIL drain_empty: got empty0=%b count0=%0d expected 1 0", empty[0], count[2:0]);
    end
  endtask

  task automatic test_isolation();
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i * 8'h11), 2'b00, 1'b0);
    step(1'b1, 1'b1, 8'hA0, 2'b00, 1'b0);
    total++;
    if (Data_out[7:0] !== 8'h11 || Data_out[15:8] !== 8'hA0) begin
      bad++;
      $display("[TB] FAIL iso_heads: got %h/%h expected 11/a0", Data_out[7:0], Data_out[15:8]);
    end
    step(1'b0, 1'b0, 8'h00, 2'b11, 1'b0);
    total++;
    if (count[2:0] !== 3'd3 || count[5:3] !== 3'd0) begin
      bad++;
      $display("[TB] FAIL iso_counts: got c0=%0d c1=%0d expected 3 0", count[2:0], count[5:3]);
    end
  endtask

  task automatic test_passthrough();
    step(1'b1, 1'b0, 8'h55, 2'b00, 1'b0);
    step(1'b1, 1'b0, 8'h66, 2'b01, 1'b0);
    total++;
    if (err_ovf !== 1'b0 || count[2:0] !== 3'd4 || full[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pass_accept: got ovf=%b count0=%0d full0=%b expected 0 4 1",
               err_ovf, count[2:0], full[0]);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 2'b01, 1'b0);
    total++;
    if (Data_out[7:0] !== 8'h66 || count[2:0] !== 3'd1) begin
      bad++;
      $display("[TB] FAIL pass_out: got %h count0=%0d expected 66 1", Data_out[7:0], count[2:0]);
    end
    step(1'b0, 1'b0, 8'h00, 2'b01, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 8'(i), 2'b00, 1'b0);
      total++;
      if (Data_out[15:8] !== 8'(i) || count[5:3] !== 3'd1) begin
        bad++;
        $display("[TB] FAIL wrap_push_%0d: got %h count1=%0d expected %h 1",
                 i, Data_out[15:8], count[5:3], 8'(i));
      end
      step(1'b0, 1'b0, 8'h00, 2'b10, 1'b0);
      total++;
      if (count[5:3] !== 3'd0 || empty[1] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL wrap_pop_%0d: got count1=%0d empty1=%b expected 0 1",
                 i, count[5:3], empty[1]);
      end
    end
  endtask

  task automatic test_underflow_and_reset();
    step(1'b1, 1'b0, 8'h77, 2'b01, 1'b0);
    total++;
    if (err_udf !== 1'b1 || count[2:0] !== 3'd1 || Data_out[7:0] !== 8'h77) begin
      bad++;
      $display("[TB] FAIL udf_set: got udf=%b count0=%0d head=%h expected 1 1 77",
               err_udf, count[2:0], Data_out[7:0]);
    end
    step(1'b0, 1'b0, 8'h00, 2'b00, 1'b1);
    total++;
    if (err_udf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL udf_clear: got udf=%b expected 0", err_udf);
    end
    step(1'b1, 1'b0, 8'h78, 2'b00, 1'b0);
    #2;
    rst_n = 1'b0;
    q0.delete(); q1.delete(); ovf_m = 1'b0; udf_m = 1'b0;
    #1;
    total++;
    if (count !== 6'd0 || empty !== 2'b11 || almost_full !== 2'b00) begin
      bad++;
      $display("[TB] FAIL async_reset: got count=%h empty=%b af=%b expected 0 11 00",
               count, empty, almost_full);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic w, vc, clr;
    logic [1:0] rd;
    for (int n = 0; n < 400; n++) begin
      w   = ($urandom_range(99) < 70);
      vc  = 1'($urandom_range(1));
      rd  = {($urandom_range(99) < 40), ($urandom_range(99) < 40)};
      clr = ($urandom_range(99) < 10);
      step(w, vc, 8'($urandom), rd, clr);
      total++;
      if (count !== exp_count() || empty !== exp_empty() || full !== exp_full() ||
          almost_full !== exp_af()) begin
        bad++;
        $display("[TB] FAIL rnd_status_%0d: got c=%h e=%b f=%b af=%b expected c=%h e=%b f=%b af=%b",
                 n, count, empty, full, almost_full, exp_count(), exp_empty(), exp_full(), exp_af());
      end
      total++;
      if (err_ovf !== ovf_m || err_udf !== udf_m) begin
        bad++;
        $display("[TB] FAIL rnd_err_%0d: got ovf=%b udf=%b expected %b %b",
                 n, err_ovf, err_udf, ovf_m, udf_m);
      end
      if (q0.size() > 0) begin
        total++;
        if (Data_out[7:0] !== q0[0]) begin
          bad++;
          $display("[TB] FAIL rnd_head0_%0d: got %h expected %h", n, Data_out[7:0], q0[0]);
        end
      end
      if (q1.size() > 0) begin
        total++;
        if (Data_out[15:8] !== q1[0]) begin
          bad++;
          $display("[TB] FAIL rnd_head1_%0d: got %h expected %h", n, Data_out[15:8], q1[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_isolation();
    test_passthrough();
    test_wrap();
    test_underflow_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
